// File: rtl/fetch_unit.sv
// fetch_unit
//
// Instruction fetch stage feeding the decoder. Holds the fetch PC and issues
// one word read at a time to the memory bus. Returned words go into a 2-entry
// prefetch queue, and the queue head is offered to decode together with its
// address. A redirect empties the queue and restarts fetch at redirect_pc.
// If a read is still outstanding at that moment, its reply is thrown away
// when it arrives.
//
// Handshakes:
//   bus side:    bus_start is a one-cycle pulse. bus_addr stays stable from
//                bus_start until the matching one-cycle bus_done. bus_data is
//                sampled only in the bus_done cycle. At most one read is
//                outstanding.
//   decode side: instr/instr_pc are valid while instr_valid=1. The head is
//                consumed in any cycle where instr_valid && instr_ready, and
//                instr_valid never depends on instr_ready.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   bus_addr/bus_start  read request to memory (word address)
//   bus_data/bus_done   read completion from memory
//   instr/instr_pc      queue head word and its address (0 when invalid)
//   instr_valid         queue non-empty
//   instr_ready         decode accepts the head this cycle
//   redirect            flush and restart fetch at redirect_pc
//   redirect_pc         new fetch address
//   fsm_state           debug view of the fetch FSM (0 = IDLE, 1 = WAIT)

module fetch_unit #(
   parameter logic [26:0] RESET_PC = 27'd0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [26:0] bus_addr,
   output logic        bus_start,
   input  logic [31:0] bus_data,
   input  logic        bus_done,
   output logic [31:0] instr,
   output logic [26:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [26:0] redirect_pc,
   output logic        fsm_state
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [26:0] fetch_pc;
   logic [26:0] addr_q;     // address of the read in flight (or the last one)
   logic        discard;    // the outstanding reply belongs to a flushed stream
   logic [1:0]  count;
   logic [26:0] head_pc;
   logic [31:0] head_word;
   logic [26:0] tail_pc;
   logic [31:0] tail_word;

   logic        issue;
   logic        push;
   logic        pop;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (issue)    state_next = S_WAIT;
         S_WAIT: if (bus_done) state_next = S_IDLE;
         default:              state_next = S_IDLE;
      endcase
   end

   // Output logic. issue is held back during reset and in a redirect cycle.
   // A reply that arrives with a redirect, or while discard is set, is
   // dropped rather than pushed.
   always_comb begin
      issue = 1'b0;
      push  = 1'b0;
      case (state)
         S_IDLE: issue = !reset && !redirect && (count != 2'd2);
         S_WAIT: push  = bus_done && !discard && !redirect;
         default: ;
      endcase
   end

   assign bus_start   = issue;
   assign bus_addr    = issue ? fetch_pc : addr_q;
   assign instr_valid = (count != 2'd0);
   assign instr       = instr_valid ? head_word : 32'd0;
   assign instr_pc    = instr_valid ? head_pc : 27'd0;
   assign pop         = instr_valid && instr_ready;
   assign fsm_state   = state;

   // Datapath: fetch PC, discard flag, and the prefetch queue (head/tail).
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc  <= RESET_PC;
         addr_q    <= 27'd0;
         discard   <= 1'b0;
         count     <= 2'd0;
         head_pc   <= 27'd0;
         head_word <= 32'd0;
         tail_pc   <= 27'd0;
         tail_word <= 32'd0;
      end else begin
         if (issue) addr_q <= fetch_pc;

         // discard is meaningful only while a read is outstanding. The reply
         // itself always clears it, even if a new redirect lands in the same
         // cycle, because no read is left outstanding after that.
         if (state == S_WAIT) begin
            if (bus_done)      discard <= 1'b0;
            else if (redirect) discard <= 1'b1;
         end

         if (redirect) begin
            // The queue is flushed. Any pop in this cycle is still treated
            // as accepted by decode.
            fetch_pc <= redirect_pc;
            count    <= 2'd0;
         end else begin
            if (push) fetch_pc <= fetch_pc + 27'd1;  // wraps modulo 2^27
            case ({push, pop})
               2'b10: begin
                  if (count == 2'd0) begin
                     head_pc   <= fetch_pc;
                     head_word <= bus_data;
                  end else begin
                     tail_pc   <= fetch_pc;
                     tail_word <= bus_data;
                  end
                  count <= count + 2'd1;
               end
               2'b01: begin
                  head_pc   <= tail_pc;
                  head_word <= tail_word;
                  count     <= count - 2'd1;
               end
               2'b11: begin
                  if (count == 2'd1) begin
                     head_pc   <= fetch_pc;
                     head_word <= bus_data;
                  end else begin
                     head_pc   <= tail_pc;
                     head_word <= tail_word;
                     tail_pc   <= fetch_pc;
                     tail_word <= bus_data;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
